// File: rtl/udma_filter_pkg.sv
// Shared types and constants for the uDMA filter TX operand stream.
// Holds the frame FSM encoding and the element datasize codes.
package udma_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    // Byte distance between consecutive elements of the given datasize.
    function automatic logic [3:0] elem_bytes(input logic [1:0] ds);
        return 4'(1) << ds;
    endfunction

endpackage

// File: rtl/udma_filter_tx_stream_if.sv
// Bus bundles for the TX stream source: the uDMA read channel (req/gnt with
// in-order read data) and the outgoing valid/ready element stream.
interface udma_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            datasize;
    logic                  gnt;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;

    modport master (output req, addr, datasize, input gnt, valid, data);
    modport slave  (input req, addr, datasize, output gnt, valid, data);
endinterface

interface udma_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            datasize;
    logic                  sof;
    logic                  eof;
    logic                  valid;
    logic                  ready;

    modport master (output data, datasize, sof, eof, valid, input ready);
    modport slave  (input data, datasize, sof, eof, valid, output ready);
endinterface

// File: rtl/udma_filter_tx_fifo.sv
// Return buffer for read data plus sof/eof tags; output is zero when empty
// so the stream presents clean zeros while idle.
module udma_filter_tx_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // A push into a full buffer is legal when the same cycle pops.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign valid_o = (cnt_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/udma_filter_tx_stream.sv
// Walks a linear/2D L2 address pattern, issues uDMA reads under a credit
// limit and returns the data as a framed valid/ready element stream.
module udma_filter_tx_stream
    import udma_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_mode_2d_i,
    input  logic [15:0]           cfg_len0_i,
    input  logic [15:0]           cfg_len1_i,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
    input  logic                  cmd_start_i,
    output logic                  busy_o,
    output logic                  done_o,
    udma_tx_if.master             tx,
    udma_stream_if.master         stream
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = DATA_WIDTH + 2;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d;
    logic [1:0]            ds_q, ds_d;
    logic [15:0]           len0_q, len0_d, rows_q, rows_d, col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic                  sof_pend_q, sof_pend_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_push, fifo_pop, fifo_valid;
    logic [FW-1:0]         fifo_wdata, fifo_rdata;
    logic [DATA_WIDTH-1:0] rdata_masked;
    logic                  credit_ok, grant, last_col, last_elem, rsp_ok, rsp_eof;
    logic [ADDR_WIDTH-1:0] elem_incr;

    // Outstanding reads plus buffered data never exceed the buffer depth,
    // so every granted read always has a slot to land in.
    assign credit_ok = ((CNT_W+1)'(outst_q) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(FIFO_DEPTH);
    assign tx.req      = (state_q == ISSUE) && credit_ok;
    assign tx.addr     = addr_q;
    assign tx.datasize = ds_q;
    assign grant       = tx.req && tx.gnt;
    assign last_col    = (col_q == len0_q - 16'd1);
    assign last_elem   = last_col && (row_q == rows_q - 16'd1);
    assign elem_incr   = ADDR_WIDTH'(elem_bytes(ds_q));

    // Responses in DRAIN with one read left must be the final element.
    assign rsp_ok  = tx.valid && (state_q != IDLE) && (outst_q != '0);
    assign rsp_eof = (state_q == DRAIN) && (outst_q == CNT_W'(1));

    always_comb begin
        rdata_masked = tx.data;
        case (ds_q)
            BYTE:    rdata_masked = {{(DATA_WIDTH-8){1'b0}}, tx.data[7:0]};
            HALF:    rdata_masked = {{(DATA_WIDTH-16){1'b0}}, tx.data[15:0]};
            WORD:    rdata_masked = tx.data;
            default: rdata_masked = tx.data;
        endcase
    end

    assign fifo_push  = rsp_ok;
    assign fifo_wdata = {sof_pend_q, rsp_eof, rdata_masked};
    assign fifo_pop   = fifo_valid && stream.ready;

    udma_filter_tx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        ds_d       = ds_q;
        len0_d     = len0_q;
        rows_d     = rows_q;
        col_d      = col_q;
        row_d      = row_q;
        outst_d    = outst_q + CNT_W'(grant) - CNT_W'(rsp_ok);
        sof_pend_d = fifo_push ? 1'b0 : sof_pend_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start_i) begin
                    addr_d     = cfg_start_addr_i;
                    row_base_d = cfg_start_addr_i;
                    stride_d   = cfg_stride_i;
                    ds_d       = cfg_datasize_i;
                    len0_d     = cfg_len0_i;
                    rows_d     = cfg_mode_2d_i ? cfg_len1_i : 16'd1;
                    col_d      = '0;
                    row_d      = '0;
                    sof_pend_d = 1'b1;
                    if ((cfg_len0_i == '0) || (cfg_mode_2d_i && (cfg_len1_i == '0))) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (grant) begin
                    if (last_col) begin
                        col_d      = '0;
                        row_d      = row_q + 16'd1;
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                    end else begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + elem_incr;
                    end
                    if (last_elem) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_rdata[DATA_WIDTH]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            ds_q       <= '0;
            len0_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            outst_q    <= '0;
            sof_pend_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            ds_q       <= ds_d;
            len0_q     <= len0_d;
            rows_q     <= rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            outst_q    <= outst_d;
            sof_pend_q <= sof_pend_d;
            done_q     <= done_d;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign stream.valid    = fifo_valid;
    assign stream.data     = fifo_rdata[DATA_WIDTH-1:0];
    assign stream.eof      = fifo_rdata[DATA_WIDTH];
    assign stream.sof      = fifo_rdata[DATA_WIDTH+1];
    assign stream.datasize = ds_q;

endmodule

// File: tb/tb_udma_filter_tx_stream.sv
// Scoreboard bench: a frame model queues expected requests and beats, a bus
// process plays memory/consumer and compares whatever the DUT presents.
module tb_udma_filter_tx_stream;
    import udma_filter_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [1:0]  ds;
    } elem_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_start_addr, cfg_stride;
    logic [1:0]  cfg_datasize;
    logic        cfg_mode_2d;
    logic [15:0] cfg_len0, cfg_len1;
    logic        cmd_start;
    logic        busy, done;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int done_due  = -1;
    int done_cnt  = 0;
    int grant_cnt = 0;
    int gnt_pct   = 100;
    int ready_pct = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int last_due  = 0;

    elem_t       exp_q[$];
    logic [33:0] exp_addr[$];
    rd_t         pend[$];

    udma_tx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) tx_bus ();
    udma_stream_if #(.DATA_WIDTH(32)) st_bus ();

    udma_filter_tx_stream #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_start_addr_i (cfg_start_addr),
        .cfg_datasize_i   (cfg_datasize),
        .cfg_mode_2d_i    (cfg_mode_2d),
        .cfg_len0_i       (cfg_len0),
        .cfg_len1_i       (cfg_len1),
        .cfg_stride_i     (cfg_stride),
        .cmd_start_i      (cmd_start),
        .busy_o           (busy),
        .done_o           (done),
        .tx               (tx_bus),
        .stream           (st_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: enumerate the frame row by row with plain arithmetic.
    task automatic modelFrame(input logic [31:0] start, input logic [1:0] ds, input logic mode2d,
                              input int len0, input int len1, input logic [31:0] stride);
        int          rows;
        int          total;
        int          n;
        logic [31:0] a;
        logic [31:0] mask;
        elem_t       e;
        rows  = mode2d ? len1 : 1;
        total = len0 * rows;
        n     = 0;
        mask  = (ds == BYTE) ? 32'h0000_00FF : (ds == HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len0; c++) begin
                a = start + 32'(r) * stride + (32'(c) << ds);
                exp_addr.push_back({ds, a});
                e.data = memWord(a) & mask;
                e.sof  = (n == 0);
                e.eof  = (n == total - 1);
                e.ds   = ds;
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] start, input logic [1:0] ds, input logic mode2d,
                                 input int len0, input int len1, input logic [31:0] stride);
        int total;
        total = mode2d ? len0 * len1 : len0;
        @(posedge clk); #2;
        modelFrame(start, ds, mode2d, len0, len1, stride);
        cfg_start_addr = start;
        cfg_datasize   = ds;
        cfg_mode_2d    = mode2d;
        cfg_len0       = 16'(len0);
        cfg_len1       = 16'(len1);
        cfg_stride     = stride;
        cmd_start      = 1'b1;
        if (total == 0) done_due = cyc + 2;
        @(posedge clk); #2;
        cmd_start      = 1'b0;
        cfg_start_addr = $urandom;
        cfg_datasize   = 2'($urandom_range(2, 0));
        cfg_mode_2d    = 1'($urandom_range(1, 0));
        cfg_len0       = 16'($urandom_range(9, 0));
        cfg_len1       = 16'($urandom_range(9, 0));
        cfg_stride     = $urandom;
        checkOutput("busy_after_start", 64'(busy), 64'(total > 0));
        checkOutput("req_after_start", 64'(tx_bus.req), 64'(total > 0));
    endtask

    task automatic waitDone(input int budget);
        int start_cnt;
        int waited;
        start_cnt = done_cnt;
        waited    = 0;
        while (done_cnt == start_cnt && waited < budget) begin
            @(posedge clk); #2;
            waited++;
        end
        checkOutput("frame_done", 64'(done_cnt - start_cnt), 64'd1);
        checkOutput("beats_left", 64'(exp_q.size()), 64'd0);
        checkOutput("reqs_left", 64'(exp_addr.size()), 64'd0);
    endtask

    // Memory, consumer and monitor in one negedge process: inputs chosen here
    // are what the next rising edge sees, so handshakes are known exactly.
    initial begin
        rd_t         r;
        logic [33:0] ea;
        elem_t       ee;
        int          due;
        logic        stall_prev;
        logic [33:0] held;
        stall_prev   = 1'b0;
        held         = '0;
        tx_bus.gnt   = 1'b0;
        tx_bus.valid = 1'b0;
        tx_bus.data  = '0;
        st_bus.ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r            = pend.pop_front();
                tx_bus.valid = 1'b1;
                tx_bus.data  = memWord(r.addr);
            end else begin
                tx_bus.valid = 1'b0;
                tx_bus.data  = '0;
            end
            tx_bus.gnt = ($urandom_range(99, 0) < gnt_pct);
            if (tx_bus.gnt && tx_bus.req && !rst) begin
                grant_cnt++;
                checkOutput("req_expected", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) begin
                    ea = exp_addr.pop_front();
                    checkOutput("req_addr", 64'({tx_bus.datasize, tx_bus.addr}), 64'(ea));
                end
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.addr   = tx_bus.addr;
                r.due    = due;
                pend.push_back(r);
            end
            st_bus.ready = ($urandom_range(99, 0) < ready_pct);
            if (stall_prev && st_bus.valid && !rst) begin
                checkOutput("stall_hold", 64'({st_bus.sof, st_bus.eof, st_bus.data}), 64'(held));
            end
            stall_prev = st_bus.valid && !st_bus.ready && !rst;
            held       = {st_bus.sof, st_bus.eof, st_bus.data};
            if (st_bus.valid && st_bus.ready && !rst) begin
                checkOutput("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ee = exp_q.pop_front();
                    checkOutput("beat", 64'({st_bus.datasize, st_bus.sof, st_bus.eof, st_bus.data}),
                                64'({ee.ds, ee.sof, ee.eof, ee.data}));
                    if (ee.eof) done_due = cyc + 1;
                end
            end
            if (done) done_cnt++;
            if (done || cyc == done_due) begin
                checkOutput("done_pulse", 64'(done), 64'(cyc == done_due));
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        int waited;
        rst            = 1'b1;
        cmd_start      = 1'b0;
        cfg_start_addr = '0;
        cfg_datasize   = '0;
        cfg_mode_2d    = 1'b0;
        cfg_len0       = '0;
        cfg_len1       = '0;
        cfg_stride     = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_req", 64'(tx_bus.req), 64'd0);
        checkOutput("reset_addr", 64'({tx_bus.datasize, tx_bus.addr}), 64'd0);
        checkOutput("reset_stream", 64'({st_bus.valid, st_bus.sof, st_bus.eof, st_bus.datasize, st_bus.data}), 64'd0);
        rst = 1'b0;

        $display("[TB] linear word frame");
        applyStimulus(32'h1000, WORD, 1'b0, 4, 0, 32'h0);
        waitDone(100);

        $display("[TB] 2D byte frame");
        applyStimulus(32'h2000, BYTE, 1'b1, 3, 2, 32'h10);
        waitDone(100);

        $display("[TB] backpressure");
        ready_pct = 0;
        g0        = grant_cnt;
        applyStimulus(32'h3000, WORD, 1'b0, 10, 0, 32'h0);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("bp_grants", 64'(grant_cnt - g0), 64'd4);
        checkOutput("bp_req_low", 64'(tx_bus.req), 64'd0);
        ready_pct = 100;
        waitDone(200);

        $display("[TB] boundary frames");
        applyStimulus(32'h3003, HALF, 1'b0, 1, 0, 32'h0);
        waitDone(100);
        applyStimulus(32'h4000, WORD, 1'b0, 0, 5, 32'h0);
        repeat (3) begin
            @(posedge clk); #2;
            checkOutput("zero_no_req", 64'(tx_bus.req), 64'd0);
        end
        applyStimulus(32'h4100, BYTE, 1'b1, 5, 0, 32'h20);
        repeat (3) begin
            @(posedge clk); #2;
            checkOutput("zero_rows_no_req", 64'(tx_bus.req), 64'd0);
        end

        $display("[TB] start while busy");
        gnt_pct   = 60;
        ready_pct = 60;
        lat_max   = 3;
        applyStimulus(32'h5000, HALF, 1'b1, 3, 3, 32'h40);
        repeat (4) @(posedge clk);
        #2;
        cfg_start_addr = 32'h9000;
        cfg_len0       = 16'd7;
        cmd_start      = 1'b1;
        @(posedge clk); #2;
        cmd_start = 1'b0;
        waitDone(400);

        $display("[TB] reset with reads outstanding");
        gnt_pct   = 100;
        ready_pct = 100;
        lat_min   = 12;
        lat_max   = 12;
        applyStimulus(32'h7000, WORD, 1'b0, 8, 0, 32'h0);
        waited = 0;
        while (pend.size() < 2 && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        gnt_pct = 0;
        checkOutput("rst_outstanding", 64'(pend.size()), 64'd2);
        rst = 1'b1;
        exp_q.delete();
        exp_addr.delete();
        done_due = -1;
        @(posedge clk); #2;
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_req", 64'(tx_bus.req), 64'd0);
        checkOutput("abort_addr", 64'({tx_bus.datasize, tx_bus.addr}), 64'd0);
        checkOutput("abort_stream", 64'({st_bus.valid, st_bus.sof, st_bus.eof, st_bus.datasize, st_bus.data}), 64'd0);
        gnt_pct = 100;
        lat_min = 1;
        lat_max = 1;
        repeat (20) begin
            @(posedge clk); #2;
            checkOutput("late_valid_dropped", 64'(st_bus.valid), 64'd0);
        end
        checkOutput("late_valid_sent", 64'(pend.size()), 64'd0);
        applyStimulus(32'h6000, WORD, 1'b0, 5, 0, 32'h0);
        waitDone(100);

        $display("[TB] randomized frames");
        for (int i = 0; i < 8; i++) begin
            gnt_pct   = $urandom_range(100, 40);
            ready_pct = $urandom_range(100, 40);
            lat_min   = 1;
            lat_max   = $urandom_range(4, 1);
            applyStimulus($urandom, 2'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
                          $urandom_range(6, 1), $urandom_range(3, 1), 32'($urandom_range(255, 0)));
            waitDone(2000);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
